// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS datapath blocks.
// Operation codes match the encoding used on the op input of hilo_muldiv.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// The accumulator packs {upper, lower}: product halves, or {remainder, quotient}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  always_comb begin
    mul_sum  = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
             + {1'b0, (acc_in[0] ? operand : {WIDTH{1'b0}})};
    div_rem  = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    div_ge   = (div_rem >= {1'b0, operand});
    // Partial remainder stays below 2*divisor, so the difference fits in WIDTH bits.
    div_diff = div_rem[WIDTH-1:0] - operand;
    if (div_mode) begin
      if (div_ge) begin
        acc_out = {div_diff, acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {div_rem[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_out = {mul_sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers and fixed 33-edge latency.
// Signed ops run on magnitudes; the FIX state restores signs and writes HI/LO.
module hilo_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               sign_quo_q, sign_quo_d;
  logic               sign_rem_q, sign_rem_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (div_q),
    .acc_in   (acc_q),
    .operand  (opnd_q),
    .acc_out  (step_acc)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    zero_d     = zero_q;
    raw_a_d    = raw_a_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    // The most negative value maps to itself, which is the right unsigned magnitude.
    is_signed = ~op[0];
    abs_a     = (is_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    abs_b     = (is_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    quo       = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          cnt_d      = '0;
          div_d      = op[1];
          sign_quo_d = is_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
          sign_rem_d = is_signed & operand_a[WIDTH-1];
          zero_d     = (operand_b == '0);
          raw_a_d    = operand_a;
          opnd_d     = abs_b;
          acc_d      = {{WIDTH{1'b0}}, abs_a};
        end else begin
          if (mthi) hi_d = operand_a;
          if (mtlo) lo_d = operand_a;
        end
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!div_q) begin
          {hi_d, lo_d} = sign_quo_q ? -acc_q : acc_q;
        end else if (zero_q) begin
          hi_d = raw_a_q;
          lo_d = '1;
        end else begin
          lo_d = sign_quo_q ? -quo : quo;
          hi_d = sign_rem_q ? -rem : rem;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= 1'b0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      zero_q     <= 1'b0;
      raw_a_q    <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      zero_q     <= zero_d;
      raw_a_q    <= raw_a_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed-vector bench for hilo_muldiv: latency, results, HI/LO moves, async reset.
module tb_hilo_muldiv;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  hilo_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an op at the current (post-negedge) time and clock it in at E0.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
  endtask

  // Counts busy cycles until done, then checks the result; returns on the done cycle.
  task automatic wait_result(input string tag, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input int exp_busy);
    int  n   = 0;
    logic got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) n++;
    end
    check({tag, "_done"}, 64'(got), 64'd1);
    check({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    $display("%s: busy=%0d hi=0x%08h lo=0x%08h", tag, n, hi, lo);
  endtask

  initial begin
    int pulses;

    // Reset state
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: unsigned extremes and single-cycle done
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 33);
    @(negedge clk);
    check("multu_done_once", 64'(done), 64'd0);

    // 2: signed multiply, then back-to-back start on the done cycle
    issue(MULT, 32'hFFFF_FFFD, 32'd7);
    wait_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    issue(MULT, 32'h8000_0000, 32'h8000_0000);
    wait_result("mult_minsq", 32'h4000_0000, 32'h0000_0000, 33);
    @(negedge clk);

    // 3: divides
    issue(DIVU, 32'd100, 32'd7);
    wait_result("divu_100_7", 32'd2, 32'd14, 33);
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_result("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div_wrap", 32'h0000_0000, 32'h8000_0000, 33);

    // 4: divide by zero
    issue(DIV, 32'h1234_5678, 32'd0);
    wait_result("div_zero", 32'h1234_5678, 32'hFFFF_FFFF, 33);
    @(negedge clk);
    check("div_zero_done_once", 64'(done), 64'd0);

    // 5: moves to HI/LO in IDLE
    mthi = 1'b1; operand_a = 32'hAAAA_0000;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", 64'(hi), 64'hAAAA_0000);
    check("mthi_lo_kept", 64'(lo), 64'hFFFF_FFFF);
    mtlo = 1'b1; operand_a = 32'h5555_AAAA;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h5555_AAAA);
    check("mtlo_hi_kept", 64'(hi), 64'hAAAA_0000);
    mthi = 1'b1; mtlo = 1'b1; operand_a = 32'h0F0F_0F0F;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_hi", 64'(hi), 64'h0F0F_0F0F);
    check("mthilo_lo", 64'(lo), 64'h0F0F_0F0F);

    // start/mthi/mtlo while busy are ignored
    issue(MULTU, 32'd2, 32'd3);
    repeat (4) @(negedge clk);
    start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
    op = DIVU; operand_a = 32'h0000_1234; operand_b = 32'd1;
    repeat (3) @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("busy_mtlo_ignored", 64'(lo), 64'h0F0F_0F0F);
    wait_result("multu_2_3", 32'd0, 32'd6, 26);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("no_queued_result", 64'(pulses), 64'd0);
    check("idle_after_ignore", 64'(busy), 64'd0);

    // start wins over mthi in the same IDLE cycle
    mthi = 1'b1;
    issue(MULTU, 32'd3, 32'd5);
    @(negedge clk);
    check("start_wins_hi", 64'(hi), 64'd0);
    wait_result("multu_3_5", 32'd0, 32'd15, 32);
    @(negedge clk);

    // 6: async reset mid-RUN
    mthi = 1'b1; operand_a = 32'hDEAD_BEEF;
    @(negedge clk);
    mthi = 1'b0;
    issue(DIVU, 32'h0000_FFFF, 32'd3);
    repeat (10) @(posedge clk);
    #3;
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_done", 64'(done), 64'd0);
    check("async_reset_hi", 64'(hi), 64'd0);
    check("async_reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(DIVU, 32'd9, 32'd3);
    wait_result("divu_9_3", 32'd0, 32'd3, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
